branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

Branch execution and in-order resolution block for the OoO core. It takes branch/jump micro-ops issued from the branch reservation station and computes direction, target and link value. It parks each outcome in a ROB-indexed table. When the ROB head commits that branch, it drives the predictor's resolve interface (`resolve_en`, `mispredict`, `resolve_rob_id`, `actual_target`) plus the front-end redirect and global flush.

## Interface
Parameters come from `params`; the block has no local overrides.
- `ROB_WIDTH`, from `params`: ROB id width.
- `ROB_SIZE`, from `params`: number of outcome-table entries.

Ports. The clock is single; reset is synchronous and active-high.
- `clk`  in  1  clock.
- `rst`  in  1  sync active-high reset.
- `iss_valid`  in  1  branch micro-op issued this cycle.
- `iss_rob_id`  in  ROB_WIDTH  ROB id of the op.
- `iss_opcode`  in  7  `op_b_br` / `op_b_jal` / `op_b_jalr`.
- `iss_funct3`  in  3  compare type, used only for `op_b_br`.
- `iss_rs1_v`, `iss_rs2_v`  in  32 each  operand values.
- `iss_pc`, `iss_imm`  in  32 each  instruction PC and sign-extended immediate.
- `iss_pred_taken`, `iss_pred_target`  in  1 / 32  prediction carried from fetch.
- `wb_valid`, `wb_rob_id`, `wb_data`  out  1 / ROB_WIDTH / 32  link writeback to CDB (jal/jalr only).
- `head_rob_id`  in  ROB_WIDTH  current ROB head.
- `br_ready`  out  1  outcome for `head_rob_id` is present (combinational).
- `commit_br`  in  1  ROB commits a branch at head this cycle. Asserted only when `br_ready`=1.
- `resolve_en`, `mispredict`  out  1 each  registered resolve pulse / mispredict flag.
- `resolve_rob_id`  out  ROB_WIDTH  id being resolved.
- `actual_target`  out  32  computed branch target, independent of direction.
- `redirect_pc`  out  32  correct next PC; meaningful only when `mispredict`=1.

## Operation
- **Stage E** (register on issue):
  - Capture the issued op.
  - Direction for `op_b_br`, by funct3: beq, bne, blt, bge signed; bltu, bgeu unsigned. Any other funct3 gives not taken.
  - jal and jalr are always taken.
- **Target:**
  - br/jal: `pc+imm`.
  - jalr: `(rs1+imm) & ~1`.
  - All arithmetic is 32-bit with wrap; carries are dropped.
- **Mispredict:** `taken != pred_taken`, or `taken && target != pred_target`.
- **Link writeback:** for jal/jalr, drive `wb_valid`=1, `wb_data=pc+4` in the stage-E output cycle.
- **Outcome table:** per ROB entry holds `valid`, `taken`, `target`, `next_pc`, `mis`. Stage E writes the entry on the clock edge closing its cycle.
- **Commit:**
  - When `commit_br`, register `resolve_en`=1 together with the entry fields, and clear that entry's `valid`.
  - `redirect_pc` = taken ? target : `pc+4`.
- **FSM states RUN and FLUSH:**
  - RUN→FLUSH on the edge where `mispredict` is registered as 1.
  - In FLUSH, all table valids and the stage-E register are cleared. `iss_valid` and `commit_br` are ignored.
  - FLUSH→RUN after exactly one cycle.
- **Reset:** state RUN. All table valids are 0. All outputs are 0: `resolve_en`, `mispredict`, `wb_valid`, `resolve_rob_id`, `actual_target`, `redirect_pc`, `wb_data`. Reset mid-operation discards every pending outcome.

## Timing
- Issue in cycle T gives `wb_valid` in T+1 and table write at the end of T+1. `br_ready` for that id is visible from T+2.
- There is no issue→commit bypass: a commit in T+1 of the same id is illegal.
- `commit_br` in cycle C gives `resolve_en`/`mispredict` high for exactly cycle C+1. They are single-cycle pulses.
- If `mispredict` is high in C+1, C+2 is FLUSH and ops issued in C+1 or C+2 are dropped. Normal operation resumes in C+3.
- Simultaneous table write to id A and commit of id B≠A in the same cycle: both take effect.
- ROB id wrap-around needs no special handling: an entry is reused only after its commit cleared it.
- `commit_br` with `br_ready`=0 is a protocol violation. The bench asserts on it.

## Structure
- `params` already holds `ROB_WIDTH` and `ROB_SIZE`.
- Add to `rv32i_types`:
  - `br_outcome_t` struct: valid, taken, mis, target, next_pc.
  - `branch_funct3_t` enum: beq=000, bne=001, blt=100, bge=101, bltu=110, bgeu=111.
- One sub-module, `branch_cmp`: a purely combinational funct3 comparator, so it can be unit-tested in isolation.

## Test plan
- **Correct beq:** beq rs1=5, rs2=5, pc=0x100, imm=0x20, pred_taken=1, pred_target=0x120, rob 3. Commit → `resolve_en`=1, `mispredict`=0, `actual_target`=0x120.
- **Direction miss:** bltu rs1=0xFFFF_FFFF, rs2=1, pred_taken=1 → not taken. `mispredict`=1, `redirect_pc`=pc+4, one FLUSH cycle, issue in that cycle dropped.
- **jalr target and link:** jalr rs1=0x1003, imm=4, pc=0x200 → `wb_data`=0x204 at T+1. `actual_target`=0x1006 (LSB cleared). pred_target=0x1000 → `mispredict`=1.
- **Signed compare:** blt rs1=-1, rs2=1 → taken. bge same operands → not taken.
- **Flush clears table:** commit a mispredicting rob 2 while rob 5's outcome is valid. `br_ready` for 5 reads 0 after FLUSH. Reissue 5 → ready at T+2.
- **Reset mid-stream:** assert `rst` with two valid entries and `resolve_en` high. The next cycle has all outputs 0 and `br_ready`=0 for every head id.

Source files
------------

// File: rtl/params.sv
// Core-wide sizing parameters shared by the out-of-order back end.
package params;
  localparam int          ROB_WIDTH = 4;
  localparam int unsigned ROB_SIZE  = 1 << ROB_WIDTH;
endpackage

// File: rtl/rv32i_types.sv
// RV32I encodings and branch-unit types shared across the core.
package rv32i_types;
  typedef enum logic [6:0] {
    op_b_br   = 7'b1100011,
    op_b_jal  = 7'b1101111,
    op_b_jalr = 7'b1100111
  } rv32i_opcode_t;

  typedef enum logic [2:0] {
    beq  = 3'b000,
    bne  = 3'b001,
    blt  = 3'b100,
    bge  = 3'b101,
    bltu = 3'b110,
    bgeu = 3'b111
  } branch_funct3_t;

  typedef struct packed {
    logic        valid;
    logic        taken;
    logic        mis;
    logic [31:0] target;
    logic [31:0] next_pc;
  } br_outcome_t;

  typedef enum logic {RUN, FLUSH} bru_state_t;
endpackage

// File: rtl/branch_cmp.sv
// Combinational conditional-branch comparator selected by funct3.
module branch_cmp
  import rv32i_types::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        taken
);
  always_comb begin
    taken = 1'b0;
    case (funct3)
      beq:     taken = (a == b);
      bne:     taken = (a != b);
      blt:     taken = ($signed(a) <  $signed(b));
      bge:     taken = ($signed(a) >= $signed(b));
      bltu:    taken = (a <  b);
      bgeu:    taken = (a >= b);
      default: taken = 1'b0;
    endcase
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// Branch execute stage, ROB-indexed outcome table and in-order resolve/redirect.
module branch_resolve_unit
  import params::*;
  import rv32i_types::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iss_valid,
  input  logic [ROB_WIDTH-1:0] iss_rob_id,
  input  logic [6:0]           iss_opcode,
  input  logic [2:0]           iss_funct3,
  input  logic [31:0]          iss_rs1_v,
  input  logic [31:0]          iss_rs2_v,
  input  logic [31:0]          iss_pc,
  input  logic [31:0]          iss_imm,
  input  logic                 iss_pred_taken,
  input  logic [31:0]          iss_pred_target,
  output logic                 wb_valid,
  output logic [ROB_WIDTH-1:0] wb_rob_id,
  output logic [31:0]          wb_data,
  input  logic [ROB_WIDTH-1:0] head_rob_id,
  output logic                 br_ready,
  input  logic                 commit_br,
  output logic                 resolve_en,
  output logic                 mispredict,
  output logic [ROB_WIDTH-1:0] resolve_rob_id,
  output logic [31:0]          actual_target,
  output logic [31:0]          redirect_pc
);
  bru_state_t state_q, state_d;
  logic flush, commit_ok;

  logic        cmp_taken, iss_link, iss_jalr, iss_taken;
  logic [31:0] iss_target;
  br_outcome_t iss_out;

  logic                 e_valid, e_link;
  logic [ROB_WIDTH-1:0] e_rob_id;
  br_outcome_t          e_out;

  br_outcome_t outcome_q [ROB_SIZE];
  br_outcome_t head_entry;

  branch_cmp u_cmp (
    .funct3 (iss_funct3),
    .a      (iss_rs1_v),
    .b      (iss_rs2_v),
    .taken  (cmp_taken)
  );

  always_comb begin
    iss_jalr   = (iss_opcode == op_b_jalr);
    iss_link   = (iss_opcode == op_b_jal) || iss_jalr;
    iss_taken  = iss_link || ((iss_opcode == op_b_br) && cmp_taken);
    iss_target = iss_jalr ? ((iss_rs1_v + iss_imm) & ~32'd1) : (iss_pc + iss_imm);
    iss_out.valid   = 1'b1;
    iss_out.taken   = iss_taken;
    iss_out.target  = iss_target;
    iss_out.next_pc = iss_pc + 32'd4;
    iss_out.mis     = (iss_taken != iss_pred_taken) ||
                      (iss_taken && (iss_target != iss_pred_target));
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (mispredict) state_d = FLUSH;
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    flush     = (state_q == FLUSH);
    commit_ok = commit_br && (state_q == RUN);
  end

  // Issues in the cycle the mispredict pulse is visible are already wrong-path.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      e_valid  <= 1'b0;
      e_link   <= 1'b0;
      e_rob_id <= '0;
      e_out    <= '0;
    end else begin
      e_valid <= iss_valid && !mispredict;
      if (iss_valid) begin
        e_link   <= iss_link;
        e_rob_id <= iss_rob_id;
        e_out    <= iss_out;
      end
    end
  end

  always_comb begin
    wb_valid  = e_valid && e_link;
    wb_rob_id = e_rob_id;
    wb_data   = e_out.next_pc;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int unsigned i = 0; i < ROB_SIZE; i++) outcome_q[i].valid <= 1'b0;
    end else begin
      if (e_valid)   outcome_q[e_rob_id]          <= e_out;
      if (commit_ok) outcome_q[head_rob_id].valid <= 1'b0;
    end
  end

  always_comb begin
    head_entry = outcome_q[head_rob_id];
    br_ready   = head_entry.valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resolve_en     <= 1'b0;
      mispredict     <= 1'b0;
      resolve_rob_id <= '0;
      actual_target  <= '0;
      redirect_pc    <= '0;
    end else begin
      resolve_en <= commit_ok;
      mispredict <= commit_ok && head_entry.mis;
      if (commit_ok) begin
        resolve_rob_id <= head_rob_id;
        actual_target  <= head_entry.target;
        redirect_pc    <= head_entry.taken ? head_entry.target : head_entry.next_pc;
      end
    end
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed issue/commit sequences.
module tb_branch_resolve_unit;
  import params::*;
  import rv32i_types::*;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 iss_valid = 1'b0;
  logic [ROB_WIDTH-1:0] iss_rob_id = '0;
  logic [6:0]           iss_opcode = '0;
  logic [2:0]           iss_funct3 = '0;
  logic [31:0]          iss_rs1_v = '0, iss_rs2_v = '0, iss_pc = '0, iss_imm = '0;
  logic                 iss_pred_taken = 1'b0;
  logic [31:0]          iss_pred_target = '0;
  logic                 wb_valid;
  logic [ROB_WIDTH-1:0] wb_rob_id;
  logic [31:0]          wb_data;
  logic [ROB_WIDTH-1:0] head_rob_id = '0;
  logic                 br_ready;
  logic                 commit_br = 1'b0;
  logic                 resolve_en, mispredict;
  logic [ROB_WIDTH-1:0] resolve_rob_id;
  logic [31:0]          actual_target, redirect_pc;

  branch_resolve_unit dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_rob_id(iss_rob_id), .iss_opcode(iss_opcode),
    .iss_funct3(iss_funct3), .iss_rs1_v(iss_rs1_v), .iss_rs2_v(iss_rs2_v),
    .iss_pc(iss_pc), .iss_imm(iss_imm), .iss_pred_taken(iss_pred_taken),
    .iss_pred_target(iss_pred_target),
    .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_data(wb_data),
    .head_rob_id(head_rob_id), .br_ready(br_ready), .commit_br(commit_br),
    .resolve_en(resolve_en), .mispredict(mispredict), .resolve_rob_id(resolve_rob_id),
    .actual_target(actual_target), .redirect_pc(redirect_pc)
  );

  always #50 clk = ~clk;

  typedef struct {
    logic [ROB_WIDTH-1:0] rob;
    logic [31:0]          data;
  } wb_exp_t;

  typedef struct {
    logic [ROB_WIDTH-1:0] rob;
    logic                 mis;
    logic [31:0]          tgt;
    logic [31:0]          redir;
  } res_exp_t;

  wb_exp_t  wb_q[$];
  res_exp_t res_q[$];
  wb_exp_t  wb_e;
  res_exp_t res_e;
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an output.
  always @(negedge clk) begin
    if (wb_valid) begin
      if (wb_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL wb_unexpected: rob %0d data 0x%08h, expected no writeback", wb_rob_id, wb_data);
      end else begin
        wb_e = wb_q.pop_front();
        chk("wb_rob_id", 32'(wb_rob_id), 32'(wb_e.rob));
        chk("wb_data", wb_data, wb_e.data);
      end
    end
    if (resolve_en) begin
      if (res_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL resolve_unexpected: rob %0d, expected no resolve pulse", resolve_rob_id);
      end else begin
        res_e = res_q.pop_front();
        chk("resolve_rob_id", 32'(resolve_rob_id), 32'(res_e.rob));
        chk("mispredict", 32'(mispredict), 32'(res_e.mis));
        chk("actual_target", actual_target, res_e.tgt);
        chk("redirect_pc", redirect_pc, res_e.redir);
      end
    end else if (mispredict) begin
      tests++; fails++;
      $display("FAIL mispredict_without_resolve: got 1 expected 0");
    end
    if (commit_br) begin
      tests++;
      if (!br_ready) begin
        fails++;
        $display("FAIL commit_protocol: commit_br with br_ready 0 for rob %0d", head_rob_id);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    iss_valid = 1'b0;
    commit_br = 1'b0;
  endtask

  task automatic set_issue(input logic [ROB_WIDTH-1:0] rob, input logic [6:0] op,
                           input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [31:0] pc, input logic [31:0] imm, input logic pt,
                           input logic [31:0] ptgt, input bit exp_wb, input logic [31:0] exp_link);
    iss_valid = 1'b1; iss_rob_id = rob; iss_opcode = op; iss_funct3 = f3;
    iss_rs1_v = rs1; iss_rs2_v = rs2; iss_pc = pc; iss_imm = imm;
    iss_pred_taken = pt; iss_pred_target = ptgt;
    if (exp_wb) wb_q.push_back('{rob, exp_link});
  endtask

  task automatic set_commit(input logic [ROB_WIDTH-1:0] rob, input logic mis,
                            input logic [31:0] tgt, input logic [31:0] redir);
    head_rob_id = rob;
    #1;
    chk("ready_at_commit", 32'(br_ready), 32'd1);
    commit_br = 1'b1;
    res_q.push_back('{rob, mis, tgt, redir});
  endtask

  task automatic check_ready(input string name, input logic [ROB_WIDTH-1:0] rob, input logic exp);
    head_rob_id = rob;
    #1;
    chk(name, 32'(br_ready), 32'(exp));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_resolve_en"}, 32'(resolve_en), 32'd0);
    chk({tag, "_mispredict"}, 32'(mispredict), 32'd0);
    chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
    chk({tag, "_resolve_rob_id"}, 32'(resolve_rob_id), 32'd0);
    chk({tag, "_actual_target"}, actual_target, 32'd0);
    chk({tag, "_redirect_pc"}, redirect_pc, 32'd0);
    chk({tag, "_wb_data"}, wb_data, 32'd0);
    for (int i = 0; i < int'(ROB_SIZE); i++) check_ready({tag, "_br_ready"}, ROB_WIDTH'(i), 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Correct beq, plus T+1 / T+2 readiness.
    set_issue(4'd3, op_b_br, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1, 32'h120, 1'b0, '0);
    tick();
    check_ready("ready_t1", 4'd3, 1'b0);
    tick();
    check_ready("ready_t2", 4'd3, 1'b1);
    set_commit(4'd3, 1'b0, 32'h120, 32'h120);
    tick(); tick();
    check_ready("cleared_after_commit", 4'd3, 1'b0);

    // bltu direction miss, flush window drops C+1/C+2 issues, C+3 accepted.
    set_issue(4'd4, op_b_br, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h40, 1'b1, 32'h340, 1'b0, '0);
    tick(); tick();
    set_commit(4'd4, 1'b1, 32'h340, 32'h304);
    tick();
    set_issue(4'd9, op_b_jal, 3'b000, '0, '0, 32'h500, 32'h8, 1'b1, 32'h508, 1'b0, '0);
    tick();
    set_issue(4'd10, op_b_jal, 3'b000, '0, '0, 32'h500, 32'h8, 1'b1, 32'h508, 1'b0, '0);
    tick();
    set_issue(4'd11, op_b_jal, 3'b000, '0, '0, 32'h400, 32'h10, 1'b1, 32'h410, 1'b1, 32'h404);
    tick(); tick();
    check_ready("dropped_c1", 4'd9, 1'b0);
    check_ready("dropped_flush", 4'd10, 1'b0);
    check_ready("accepted_c3", 4'd11, 1'b1);
    check_ready("mis_entry_cleared", 4'd4, 1'b0);
    set_commit(4'd11, 1'b0, 32'h410, 32'h410);
    tick(); tick();

    // jalr: LSB cleared, link pc+4, target mispredict.
    set_issue(4'd6, op_b_jalr, 3'b000, 32'h1003, '0, 32'h200, 32'h4, 1'b1, 32'h1000, 1'b1, 32'h204);
    tick(); tick();
    set_commit(4'd6, 1'b1, 32'h1006, 32'h1006);
    tick(); tick(); tick();

    // Compare variants and wrap; commit of 7 overlaps the table write of 14.
    set_issue(4'd7, op_b_br, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h600, 32'h10, 1'b1, 32'h610, 1'b0, '0);
    tick();
    set_issue(4'd8, op_b_br, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'h700, 32'h10, 1'b0, 32'h0, 1'b0, '0);
    tick();
    set_issue(4'd12, op_b_br, 3'b001, 32'd5, 32'd6, 32'h800, 32'hFFFF_FFF0, 1'b1, 32'h7F0, 1'b0, '0);
    tick();
    set_issue(4'd13, op_b_br, 3'b111, 32'd1, 32'hFFFF_FFFF, 32'h900, 32'h8, 1'b0, 32'h0, 1'b0, '0);
    tick();
    set_issue(4'd14, op_b_br, 3'b010, 32'd0, 32'd0, 32'hA00, 32'h40, 1'b0, 32'h0, 1'b0, '0);
    tick();
    set_issue(4'd15, op_b_br, 3'b000, 32'd7, 32'd7, 32'hFFFF_FFF0, 32'h20, 1'b1, 32'h10, 1'b0, '0);
    set_commit(4'd7, 1'b0, 32'h610, 32'h610);
    tick();
    set_commit(4'd8, 1'b0, 32'h710, 32'h704);
    tick();
    set_commit(4'd12, 1'b0, 32'h7F0, 32'h7F0);
    tick();
    set_commit(4'd13, 1'b0, 32'h908, 32'h904);
    tick();
    set_commit(4'd14, 1'b0, 32'hA40, 32'hA04);
    tick();
    set_commit(4'd15, 1'b0, 32'h10, 32'h10);
    tick(); tick();

    // Flush wipes a pending valid entry; reissue becomes ready at T+2.
    set_issue(4'd2, op_b_br, 3'b000, 32'd1, 32'd2, 32'hA80, 32'h20, 1'b1, 32'hAA0, 1'b0, '0);
    tick();
    set_issue(4'd5, op_b_jal, 3'b000, '0, '0, 32'hB00, 32'h100, 1'b1, 32'hC00, 1'b1, 32'hB04);
    tick(); tick();
    check_ready("pre_flush_valid", 4'd5, 1'b1);
    set_commit(4'd2, 1'b1, 32'hAA0, 32'hA84);
    tick(); tick(); tick();
    check_ready("post_flush_cleared", 4'd5, 1'b0);
    set_issue(4'd5, op_b_jal, 3'b000, '0, '0, 32'hB00, 32'h100, 1'b1, 32'hC00, 1'b1, 32'hB04);
    tick();
    check_ready("reissue_t1", 4'd5, 1'b0);
    tick();
    check_ready("reissue_t2", 4'd5, 1'b1);
    set_commit(4'd5, 1'b0, 32'hC00, 32'hC00);
    tick(); tick();

    // Reset while resolve_en is high and two outcomes are pending.
    set_issue(4'd0, op_b_jal, 3'b000, '0, '0, 32'hD00, 32'h8, 1'b1, 32'hD08, 1'b1, 32'hD04);
    tick();
    set_issue(4'd1, op_b_br, 3'b000, 32'd3, 32'd3, 32'hE00, 32'h10, 1'b1, 32'hE10, 1'b0, '0);
    tick();
    set_issue(4'd2, op_b_br, 3'b001, 32'd3, 32'd3, 32'hF00, 32'h10, 1'b0, 32'h0, 1'b0, '0);
    tick();
    set_commit(4'd0, 1'b0, 32'hD08, 32'hD08);
    tick();
    chk("resolve_before_reset", 32'(resolve_en), 32'd1);
    rst = 1'b1;
    tick();
    check_all_zero("midreset");
    rst = 1'b0;
    tick(); tick();

    chk("wb_queue_drained", 32'(wb_q.size()), 32'd0);
    chk("resolve_queue_drained", 32'(res_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
